clk_meas: RTL and testbench

//   Measures a clock-like signal sig_in against a reference edge ref_in, both

---
 rtl/clk_meas_if.sv | 26 ++
 rtl/clk_meas.sv | 195 +++++++++++++++++++
 tb/tb_clk_meas.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_meas_if.sv
// Bus between the clock-measurement block and its user: the start request,
// the two asynchronous inputs being measured, status flags and result fields.
interface clk_meas_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             sig_in;
  logic             ref_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] t_on;
  logic [CNT_W-1:0] t_off;
  logic [CNT_W:0]   period;

  modport master (
    output start, sig_in, ref_in,
    input  busy, done, timeout, phase, t_on, t_off, period
  );

  modport slave (
    input  start, sig_in, ref_in,
    output busy, done, timeout, phase, t_on, t_off, period
  );
endinterface

// File: rtl/clk_meas.sv
// Clock waveform checker: measures the phase of sig_in relative to a ref_in
// rising edge, then the high time, low time and period of sig_in, all in clk
// cycles. One measurement per accepted start pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results hold their last values
// ARM   | results cleared, waiting for a ref rise
// PHASE | counting from ref rise to the next sig rise
// HIGH  | counting from sig rise to sig fall
// LOW   | counting from sig fall to the next sig rise
// DONE  | one cycle, done asserted, results valid
module clk_meas #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  clk_meas_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PHASE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sig_sync_q;
  logic [SYNC_STAGES-1:0] ref_sync_q;
  logic                   sig_dly_q;
  logic                   ref_dly_q;
  logic                   sig_s;
  logic                   ref_s;
  logic                   sig_rise;
  logic                   sig_fall;
  logic                   ref_rise;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_at_max;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] t_on_q;
  logic [CNT_W-1:0] t_off_q;
  logic [CNT_W:0]   period_q;

  // Synchronise both inputs through equal-length chains, plus one delay flop
  // each for edge detection, so the latency cancels in every interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_sync_q <= '0;
      ref_sync_q <= '0;
      sig_dly_q  <= 1'b0;
      ref_dly_q  <= 1'b0;
    end else begin
      sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], bus.sig_in};
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], bus.ref_in};
      sig_dly_q  <= sig_sync_q[SYNC_STAGES-1];
      ref_dly_q  <= ref_sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s    = sig_sync_q[SYNC_STAGES-1];
  assign ref_s    = ref_sync_q[SYNC_STAGES-1];
  assign sig_rise = sig_s & ~sig_dly_q;
  assign sig_fall = ~sig_s & sig_dly_q;
  assign ref_rise = ref_s & ~ref_dly_q;

  // The counter is loaded with 1 on every transition, so the value seen in
  // the cycle of the closing edge equals the edge-to-edge distance.
  assign cnt_at_max = (cnt_q == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + 1'b1;

  // Measurement sequencer; all status and result outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      phase_q   <= '0;
      t_on_q    <= '0;
      t_off_q   <= '0;
      period_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_ARM;
            busy_q    <= 1'b1;
            cnt_q     <= {{(CNT_W-1){1'b0}}, 1'b1};
            timeout_q <= 1'b0;
            phase_q   <= '0;
            t_on_q    <= '0;
            t_off_q   <= '0;
            period_q  <= '0;
          end
        end
        S_ARM: begin
          if (ref_rise) begin
            cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (sig_rise) begin
              // coincident edges: zero phase, start timing the high phase now
              phase_q <= '0;
              state_q <= S_HIGH;
            end else begin
              state_q <= S_PHASE;
            end
          end else if (cnt_at_max) begin
            // no reference ever arrived; nothing has been measured yet
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_PHASE: begin
          if (sig_rise) begin
            phase_q <= cnt_q;
            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= S_HIGH;
          end else if (cnt_at_max) begin
            phase_q   <= CNT_MAX;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_HIGH: begin
          if (sig_fall) begin
            t_on_q  <= cnt_q;
            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= S_LOW;
          end else if (cnt_at_max) begin
            t_on_q    <= CNT_MAX;
            period_q  <= {1'b0, CNT_MAX} + {1'b0, t_off_q};
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_LOW: begin
          if (sig_rise) begin
            t_off_q  <= cnt_q;
            period_q <= {1'b0, t_on_q} + {1'b0, cnt_q};
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (cnt_at_max) begin
            t_off_q   <= CNT_MAX;
            period_q  <= {1'b0, t_on_q} + {1'b0, CNT_MAX};
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.phase   = phase_q;
  assign bus.t_on    = t_on_q;
  assign bus.t_off   = t_off_q;
  assign bus.period  = period_q;

endmodule

// File: tb/tb_clk_meas.sv
// Bench for clk_meas: drives edge schedules on ref_in/sig_in and compares the
// reported intervals with the intervals it scheduled, saturated at 2^CNT_W-1.
module tb_clk_meas;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int NEVER = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  int   cyc        = 0;
  int   done_cnt   = 0;
  int   done_cyc   = 0;
  logic prev_done  = 1'b0;
  logic busy_after = 1'b0;
  logic done_after = 1'b0;

  clk_meas_if #(.CNT_W(CNT_W)) bus ();

  clk_meas #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // free-running cycle count
  always @(posedge clk) cyc <= cyc + 1;

  // record every done pulse and what the status looked like one cycle later
  always @(negedge clk) begin
    prev_done <= bus.done;
    if (prev_done === 1'b1) begin
      busy_after <= bus.busy;
      done_after <= bus.done;
    end
    if (bus.done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the three scheduled intervals are reported in order; the first
  // one that exceeds the counter range reads as full scale, ends the run with
  // timeout, and leaves later fields at zero.
  function automatic void model(input int p, input int on, input int off,
                                output int ep, output int eon, output int eoff,
                                output int eper, output int eto);
    int iv[3];
    int res[3];
    iv  = '{p, on, off};
    res = '{0, 0, 0};
    eto = 0;
    for (int i = 0; i < 3; i++) begin
      if (iv[i] > MAXV) begin
        res[i] = MAXV;
        eto    = 1;
        break;
      end
      res[i] = iv[i];
    end
    ep   = res[0];
    eon  = res[1];
    eoff = res[2];
    eper = res[1] + res[2];
  endfunction

  // One measurement: ref rises, sig rises p cycles later, stays high for on,
  // low for off, then rises again. Intervals above MAXV are never closed.
  task automatic measure(input string name, input int p, input int on, input int off,
                         input bit start_mid);
    int ep, eon, eoff, eper, eto;
    int d0, tref;
    model(p, on, off, ep, eon, eoff, eper, eto);
    d0 = done_cnt;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    bus.ref_in = 1'b1;
    tref = cyc;
    if (p > MAXV) begin
      tick(MAXV + 10);
    end else begin
      if (p > 0) tick(p);
      bus.sig_in = 1'b1;
      if (on > MAXV) begin
        tick(MAXV + 10);
      end else begin
        tick(on);
        bus.sig_in = 1'b0;
        if (start_mid) bus.start = 1'b1;
        if (off > MAXV) begin
          tick(1);
          bus.start = 1'b0;
          tick(MAXV + 10);
        end else begin
          tick(1);
          bus.start = 1'b0;
          if (off > 1) tick(off - 1);
          bus.sig_in = 1'b1;
          tick(1);
        end
      end
    end
    tick(SYNC + 4);
    bus.sig_in = 1'b0;
    bus.ref_in = 1'b0;
    tick(SYNC + 4);
    chk({name, ".done_pulses"}, done_cnt - d0, 1);
    chk({name, ".phase"}, bus.phase, ep);
    chk({name, ".t_on"}, bus.t_on, eon);
    chk({name, ".t_off"}, bus.t_off, eoff);
    chk({name, ".period"}, bus.period, eper);
    chk({name, ".timeout"}, bus.timeout, eto);
    chk({name, ".busy_after_done"}, busy_after, 0);
    chk({name, ".done_width"}, done_after, 0);
    chk({name, ".busy_idle"}, bus.busy, 0);
    if (p > MAXV) chk({name, ".latency"}, done_cyc - tref, SYNC + 1 + MAXV);
  endtask

  initial begin
    int d0;
    bus.start  = 1'b0;
    bus.sig_in = 1'b0;
    bus.ref_in = 1'b0;

    tick(3);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.timeout", bus.timeout, 0);
    chk("reset.phase", bus.phase, 0);
    chk("reset.period", bus.period, 0);
    rst_n = 1'b1;
    tick(3);

    measure("t1", 4, 3, 7, 1'b0);
    measure("t2_sat_phase", NEVER, 0, 0, 1'b0);
    measure("t3_coincident", 0, 5, 5, 1'b0);
    measure("t4_start_in_high", 4, 3, 7, 1'b1);

    // abort in HIGH with an asynchronous reset
    d0 = done_cnt;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    bus.ref_in = 1'b1;
    tick(4);
    bus.sig_in = 1'b1;
    tick(4);
    chk("t5.busy_before", bus.busy, 1);
    chk("t5.phase_before", bus.phase, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.busy_rst", bus.busy, 0);
    chk("t5.phase_rst", bus.phase, 0);
    chk("t5.done_rst", bus.done, 0);
    tick(2);
    bus.sig_in = 1'b0;
    bus.ref_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t5.no_done", done_cnt - d0, 0);
    measure("t5_after_reset", 4, 3, 7, 1'b0);

    measure("t6_toggle", 2, 1, 1, 1'b0);
    measure("sat_high", 3, NEVER, 5, 1'b0);
    measure("sat_low", 3, 4, NEVER, 1'b0);
    measure("full_scale_high", 2, MAXV, 3, 1'b0);

    for (int i = 0; i < 20; i++) begin
      measure("rand", $urandom_range(0, 30), $urandom_range(1, 30),
              $urandom_range(1, 30), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
